// File: rtl/operand_fetch_if.sv
// Operand-fetch bus bundle: decode handshake, register-file read ports,
// writeback snoop and the execute handshake.
interface operand_fetch_if #(
    parameter int DATA_W    = 32,
    parameter int RF_ADDR_W = 32
);
    // decode side
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_instr;
    logic                 in_uses_rt;
    // register file read ports
    logic [RF_ADDR_W-1:0] rf_read_addr_1;
    logic [RF_ADDR_W-1:0] rf_read_addr_2;
    logic                 rf_second_read;
    logic [DATA_W-1:0]    rf_read_data_1;
    logic [DATA_W-1:0]    rf_read_data_2;
    // writeback snoop
    logic                 wb_enable;
    logic [4:0]           wb_addr;
    logic [DATA_W-1:0]    wb_data;
    // execute side
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_instr;
    logic [DATA_W-1:0]    op_a;
    logic [DATA_W-1:0]    op_b;

    // Surroundings of the stage: decode, register file, writeback, execute.
    modport master (
        output in_valid, in_instr, in_uses_rt,
        output rf_read_data_1, rf_read_data_2,
        output wb_enable, wb_addr, wb_data,
        output out_ready,
        input  in_ready, rf_read_addr_1, rf_read_addr_2, rf_second_read,
        input  out_valid, out_instr, op_a, op_b
    );

    // The operand-fetch stage itself.
    modport slave (
        input  in_valid, in_instr, in_uses_rt,
        input  rf_read_data_1, rf_read_data_2,
        input  wb_enable, wb_addr, wb_data,
        input  out_ready,
        output in_ready, rf_read_addr_1, rf_read_addr_2, rf_second_read,
        output out_valid, out_instr, op_a, op_b
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand-fetch stage: latches an instruction, reads rs/rt from a register
// file with one-cycle read latency, forwards writeback data that races the
// read, and holds the operands for execute under valid/ready.
module operand_fetch #(
    parameter int DATA_W    = 32,
    parameter int RF_ADDR_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    operand_fetch_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READ    = 2'd1,
        S_CAPTURE = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [31:0]       r_instr;
    logic [4:0]        r_rs;
    logic [4:0]        r_rt;
    logic              r_uses_rt;
    logic [DATA_W-1:0] r_byp_a;
    logic [DATA_W-1:0] r_byp_b;
    logic              r_flag_a;
    logic              r_flag_b;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic              r_out_valid;

    logic              w_in_ready;
    logic              w_second_read;
    logic              w_hit_a;
    logic              w_hit_b;
    logic              w_handoff;
    logic [DATA_W-1:0] w_cap_a;
    logic [DATA_W-1:0] w_cap_b;

    // A writeback hits an operand only for a nonzero index; rt only when used.
    assign w_hit_a   = bus.wb_enable && (bus.wb_addr == r_rs) && (r_rs != 5'd0);
    assign w_hit_b   = bus.wb_enable && (bus.wb_addr == r_rt) && (r_rt != 5'd0) && r_uses_rt;
    assign w_handoff = (r_state == S_HOLD) && r_out_valid && bus.out_ready;

    // State register.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state and handshake/read-port strobes.
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        w_next_state  = r_state;
        w_in_ready    = 1'b0;
        w_second_read = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next_state = S_READ;
            end
            S_READ: begin
                w_second_read = r_uses_rt;
                w_next_state  = S_CAPTURE;
            end
            S_CAPTURE: w_next_state = S_HOLD;
            S_HOLD:    if (w_handoff) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Operand selection at capture: r0, then live writeback, then stored bypass, then RF.
    always_comb begin
        w_cap_a = '0;
        w_cap_b = '0;
        if (r_rs != 5'd0) begin
            if (w_hit_a)       w_cap_a = bus.wb_data;
            else if (r_flag_a) w_cap_a = r_byp_a;
            else               w_cap_a = bus.rf_read_data_1;
        end
        if (r_uses_rt && (r_rt != 5'd0)) begin
            if (w_hit_b)       w_cap_b = bus.wb_data;
            else if (r_flag_b) w_cap_b = r_byp_b;
            else               w_cap_b = bus.rf_read_data_2;
        end
    end

    // Datapath: latch on accept, snoop writeback during the read, load and hold operands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instr     <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_uses_rt   <= 1'b0;
            r_byp_a     <= '0;
            r_byp_b     <= '0;
            r_flag_a    <= 1'b0;
            r_flag_b    <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_instr   <= bus.in_instr;
                        r_rs      <= bus.in_instr[25:21];
                        r_rt      <= bus.in_instr[20:16];
                        r_uses_rt <= bus.in_uses_rt;
                    end
                end
                S_READ: begin
                    // The RF write lands on this same edge, so the RF returns the stale value.
                    if (w_hit_a) begin
                        r_byp_a  <= bus.wb_data;
                        r_flag_a <= 1'b1;
                    end
                    if (w_hit_b) begin
                        r_byp_b  <= bus.wb_data;
                        r_flag_b <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    r_op_a      <= w_cap_a;
                    r_op_b      <= w_cap_b;
                    r_out_valid <= 1'b1;
                end
                S_HOLD: begin
                    if (w_hit_a) r_op_a <= bus.wb_data;
                    if (w_hit_b) r_op_b <= bus.wb_data;
                    if (w_handoff) begin
                        r_out_valid <= 1'b0;
                        r_flag_a    <= 1'b0;
                        r_flag_b    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready       = w_in_ready;
    assign bus.rf_second_read = w_second_read;
    assign bus.rf_read_addr_1 = {{(RF_ADDR_W-5){1'b0}}, r_rs};
    assign bus.rf_read_addr_2 = {{(RF_ADDR_W-5){1'b0}}, r_rt};
    assign bus.out_valid      = r_out_valid;
    assign bus.out_instr      = r_instr;
    assign bus.op_a           = r_op_a;
    assign bus.op_b           = r_op_b;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: a behavioural register file with one-cycle read
// latency, directed scenarios, and a randomized run against an
// architectural-register reference model.
module tb_operand_fetch;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    operand_fetch_if #(.DATA_W(32), .RF_ADDR_W(32)) bus ();

    operand_fetch #(.DATA_W(32), .RF_ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Register file: synchronous read, write visible to reads one edge later.
    logic [31:0] rf [32];
    always @(posedge clk) begin
        bus.rf_read_data_1 <= rf[bus.rf_read_addr_1[4:0]];
        bus.rf_read_data_2 <= rf[bus.rf_read_addr_2[4:0]];
        if (bus.wb_enable) rf[bus.wb_addr] <= bus.wb_data;
    end

    // Reference: architectural register contents after every committed writeback.
    logic [31:0] arch [32];
    always @(posedge clk) begin
        if (bus.wb_enable) arch[bus.wb_addr] <= bus.wb_data;
    end

    function automatic logic [31:0] reg_value(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'd0 : arch[idx];
    endfunction

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt);
        return {6'd0, rs, rt, 5'd3, 5'd0, 6'h20};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
        $fatal(1);
    end

    // ---- stimulus helpers (drive only; called at a falling edge) ----
    task automatic load_rf(input logic [4:0] idx, input logic [31:0] val);
        bus.wb_enable = 1'b1;
        bus.wb_addr   = idx;
        bus.wb_data   = val;
        @(negedge clk);
        bus.wb_enable = 1'b0;
    endtask

    task automatic restore();
        load_rf(5'd1, 32'd1);
        load_rf(5'd2, 32'd3);
    endtask

    task automatic wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
        bus.wb_enable = en;
        bus.wb_addr   = addr;
        bus.wb_data   = data;
    endtask

    // Present an instruction, returning at the falling edge of the READ cycle.
    task automatic issue(input logic [31:0] instr, input logic uses);
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL issue_wait in_ready=%b required 1", bus.in_ready); else n_pass++;
        bus.in_valid   = 1'b1;
        bus.in_instr   = instr;
        bus.in_uses_rt = uses;
        @(negedge clk);
        bus.in_valid   = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++)
            load_rf(5'(i), (i == 1) ? 32'd1 : (i == 2) ? 32'd3 : $urandom);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset in_ready got %b exp 1", bus.in_ready); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset out_valid got %b exp 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.op_a !== 32'd0) $display("FAIL reset op_a got %h exp 0", bus.op_a); else n_pass++;
        n_checks++; if (bus.op_b !== 32'd0) $display("FAIL reset op_b got %h exp 0", bus.op_b); else n_pass++;
        n_checks++; if (bus.out_instr !== 32'd0) $display("FAIL reset out_instr got %h exp 0", bus.out_instr); else n_pass++;
        n_checks++; if (bus.rf_read_addr_1 !== 32'd0) $display("FAIL reset rf_addr_1 got %h exp 0", bus.rf_read_addr_1); else n_pass++;
        n_checks++; if (bus.rf_second_read !== 1'b0) $display("FAIL reset second_read got %b exp 0", bus.rf_second_read); else n_pass++;
    endtask

    task automatic test_basic();
        issue(mk(5'd1, 5'd2), 1'b1);
        n_checks++; if (bus.rf_second_read !== 1'b1) $display("FAIL basic second_read got %b exp 1", bus.rf_second_read); else n_pass++;
        n_checks++; if (bus.rf_read_addr_1 !== 32'd1) $display("FAIL basic rf_addr_1 got %h exp 1", bus.rf_read_addr_1); else n_pass++;
        n_checks++; if (bus.rf_read_addr_2 !== 32'd2) $display("FAIL basic rf_addr_2 got %h exp 2", bus.rf_read_addr_2); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL basic read in_ready got %b exp 0", bus.in_ready); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL basic capture out_valid got %b exp 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.rf_second_read !== 1'b0) $display("FAIL basic capture second_read got %b exp 0", bus.rf_second_read); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL basic latency out_valid got %b exp 1", bus.out_valid); else n_pass++;
        n_checks++; if (bus.op_a !== 32'd1) $display("FAIL basic op_a got %h exp 1", bus.op_a); else n_pass++;
        n_checks++; if (bus.op_b !== 32'd3) $display("FAIL basic op_b got %h exp 3", bus.op_b); else n_pass++;
        n_checks++; if (bus.out_instr !== mk(5'd1, 5'd2)) $display("FAIL basic out_instr got %h exp %h", bus.out_instr, mk(5'd1, 5'd2)); else n_pass++;
        drain();
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL basic handoff in_ready got %b exp 1", bus.in_ready); else n_pass++;
    endtask

    task automatic test_bypass_read();
        restore();
        issue(mk(5'd1, 5'd2), 1'b1);
        wb(1'b1, 5'd1, 32'h55);
        @(negedge clk);
        wb(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        n_checks++; if (bus.op_a !== 32'h55) $display("FAIL bypass_read op_a got %h exp 55", bus.op_a); else n_pass++;
        n_checks++; if (bus.op_b !== 32'd3) $display("FAIL bypass_read op_b got %h exp 3", bus.op_b); else n_pass++;
        drain();
    endtask

    task automatic test_wb_capture_hold();
        restore();
        issue(mk(5'd1, 5'd2), 1'b1);
        @(negedge clk);
        wb(1'b1, 5'd2, 32'hAA);
        @(negedge clk);
        n_checks++; if (bus.op_b !== 32'hAA) $display("FAIL capture_fwd op_b got %h exp aa", bus.op_b); else n_pass++;
        n_checks++; if (bus.op_a !== 32'd1) $display("FAIL capture_fwd op_a got %h exp 1", bus.op_a); else n_pass++;
        wb(1'b1, 5'd2, 32'hBB);
        @(negedge clk);
        wb(1'b0, 5'd0, 32'd0);
        n_checks++; if (bus.op_b !== 32'hBB) $display("FAIL hold_fwd op_b got %h exp bb", bus.op_b); else n_pass++;
        n_checks++; if (bus.op_a !== 32'd1) $display("FAIL hold_fwd op_a got %h exp 1", bus.op_a); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL hold_fwd out_valid got %b exp 1", bus.out_valid); else n_pass++;
        drain();
    endtask

    task automatic test_no_rt_and_r0();
        restore();
        issue(mk(5'd2, 5'd1), 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.rf_second_read !== 1'b0) $display("FAIL no_rt second_read cycle %0d got %b exp 0", i, bus.rf_second_read); else n_pass++;
            if (i < 2) @(negedge clk);
        end
        n_checks++; if (bus.op_a !== 32'd3) $display("FAIL no_rt op_a got %h exp 3", bus.op_a); else n_pass++;
        n_checks++; if (bus.op_b !== 32'd0) $display("FAIL no_rt op_b got %h exp 0", bus.op_b); else n_pass++;
        drain();
        issue(mk(5'd0, 5'd1), 1'b1);
        wb(1'b1, 5'd0, 32'd7);
        @(negedge clk);
        wb(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        n_checks++; if (bus.op_a !== 32'd0) $display("FAIL r0 op_a got %h exp 0", bus.op_a); else n_pass++;
        n_checks++; if (bus.op_b !== 32'd1) $display("FAIL r0 op_b got %h exp 1", bus.op_b); else n_pass++;
        drain();
    endtask

    task automatic test_backpressure();
        restore();
        issue(mk(5'd1, 5'd2), 1'b1);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL stall out_valid cycle %0d got %b exp 1", i, bus.out_valid); else n_pass++;
            n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL stall in_ready cycle %0d got %b exp 0", i, bus.in_ready); else n_pass++;
            n_checks++; if (bus.op_a !== 32'd1 || bus.op_b !== 32'd3) $display("FAIL stall operands cycle %0d got %h/%h exp 1/3", i, bus.op_a, bus.op_b); else n_pass++;
            n_checks++; if (bus.out_instr !== mk(5'd1, 5'd2)) $display("FAIL stall out_instr cycle %0d got %h exp %h", i, bus.out_instr, mk(5'd1, 5'd2)); else n_pass++;
            bus.in_valid = 1'b1;
            bus.in_instr = mk(5'd3, 5'd4);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        drain();
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL stall release in_ready got %b exp 1", bus.in_ready); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL stall release out_valid got %b exp 0", bus.out_valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        restore();
        issue(mk(5'd1, 5'd2), 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL mid_reset out_valid got %b exp 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL mid_reset in_ready got %b exp 1", bus.in_ready); else n_pass++;
        n_checks++; if (bus.op_a !== 32'd0 || bus.op_b !== 32'd0) $display("FAIL mid_reset operands got %h/%h exp 0/0", bus.op_a, bus.op_b); else n_pass++;
        n_checks++; if (bus.out_instr !== 32'd0) $display("FAIL mid_reset out_instr got %h exp 0", bus.out_instr); else n_pass++;
        issue(mk(5'd2, 5'd1), 1'b1);
        @(negedge clk);
        bus.out_ready = 1'b1;  // already high in CAPTURE: must not shorten HOLD
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL early_ready out_valid got %b exp 1", bus.out_valid); else n_pass++;
        n_checks++; if (bus.op_a !== 32'd3 || bus.op_b !== 32'd1) $display("FAIL after_reset operands got %h/%h exp 3/1", bus.op_a, bus.op_b); else n_pass++;
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL early_ready handoff in_ready got %b exp 1", bus.in_ready); else n_pass++;
    endtask

    task automatic test_random();
        bit          busy = 1'b0;
        int          age = 0;
        logic [31:0] cur = '0;
        logic        cur_uses = 1'b0;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.in_valid   = ($urandom_range(0, 1) == 1);
            bus.in_instr   = {6'd0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
            bus.in_uses_rt = ($urandom_range(0, 1) == 1);
            wb(($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom);
            bus.out_ready  = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            if (!busy) begin
                if (bus.in_valid) begin
                    busy = 1'b1;
                    age = 1;
                    cur = bus.in_instr;
                    cur_uses = bus.in_uses_rt;
                end
            end else if (age >= 3 && bus.out_ready) begin
                busy = 1'b0;
            end else begin
                age++;
            end
            @(negedge clk);
            n_checks++; if (bus.in_ready !== !busy) $display("FAIL rand in_ready cyc %0d got %b exp %b", cyc, bus.in_ready, !busy); else n_pass++;
            n_checks++; if (bus.out_valid !== (busy && age >= 3)) $display("FAIL rand out_valid cyc %0d got %b exp %b", cyc, bus.out_valid, busy && age >= 3); else n_pass++;
            n_checks++; if (bus.rf_second_read !== (busy && age == 1 && cur_uses)) $display("FAIL rand second_read cyc %0d got %b exp %b", cyc, bus.rf_second_read, busy && age == 1 && cur_uses); else n_pass++;
            if (busy && age >= 3) begin
                exp_a = reg_value(cur[25:21]);
                exp_b = cur_uses ? reg_value(cur[20:16]) : 32'd0;
                n_checks++; if (bus.op_a !== exp_a) $display("FAIL rand op_a cyc %0d got %h exp %h", cyc, bus.op_a, exp_a); else n_pass++;
                n_checks++; if (bus.op_b !== exp_b) $display("FAIL rand op_b cyc %0d got %h exp %h", cyc, bus.op_b, exp_b); else n_pass++;
                n_checks++; if (bus.out_instr !== cur) $display("FAIL rand out_instr cyc %0d got %h exp %h", cyc, bus.out_instr, cur); else n_pass++;
            end
        end
        bus.in_valid = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        bus.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_instr   = '0;
        bus.in_uses_rt = 1'b0;
        bus.out_ready  = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        test_reset();
        test_basic();
        test_bypass_read();
        test_wb_capture_hold();
        test_no_rt_and_r0();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
